mem_arbiter: RTL and testbench

Memory arbiter and load/store front end sitting directly upstream of the single-port synchronous data RAM. Accepts requests from two masters, the CPU load/store path (read/write) and the video fetch path (read-only), and grants one RAM access per cycle by round-robin. Drives the RAM's enable/read/write/address/data ports and routes the RAM's one-cycle-late read data back to the requester that issued it. Optionally decodes a memory-mapped I/O window for switches and LEDs on the CPU port.

---
 rtl/mem_pkg.sv | 11 +
 rtl/mem_mmio_regs.sv | 43 ++++
 rtl/mem_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_arbiter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types for the data-memory arbiter: read-owner tracking, requester id, MMIO offsets.
package mem_pkg;
  typedef enum logic {CPU = 1'b0, VIDEO = 1'b1} requester_t;
`ifdef MEM_ARBITER_MMIO_EN
  typedef enum logic [1:0] {NONE, CPU_RAM, VID_RAM, CPU_MMIO} rd_owner_t;
`else
  typedef enum logic [1:0] {NONE, CPU_RAM, VID_RAM} rd_owner_t;
`endif
  localparam int SW_OFS  = 0;
  localparam int LED_OFS = 1;
endpackage

// File: rtl/mem_mmio_regs.sv
// CPU I/O window: combinational decode and read mux, LED register written on the accepting edge.
// Switches are read-only; unmapped window addresses read 0 and ignore writes.
module mem_mmio_regs
  import mem_pkg::*;
#(
  parameter int                       WIDTH         = 16,
  parameter int                       RAM_ADDR_BITS = 16,
  parameter logic [RAM_ADDR_BITS-1:0] MMIO_BASE     = 16'hFF00
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [RAM_ADDR_BITS-1:0] addr,
  input  logic                     wr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [WIDTH-1:0]         switches,
  output logic                     sel,
  output logic [WIDTH-1:0]         rd_val,
  output logic [WIDTH-1:0]         leds
);
  logic [RAM_ADDR_BITS-1:0] ofs;
  logic [WIDTH-1:0]         led_q;

  assign sel  = (addr >= MMIO_BASE);
  assign ofs  = addr - MMIO_BASE;
  assign leds = led_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      led_q <= '0;
    end else if (wr && sel && (ofs == RAM_ADDR_BITS'(LED_OFS))) begin
      led_q <= wdata;
    end
  end

  always_comb begin
    rd_val = '0;
    if (sel && (ofs == RAM_ADDR_BITS'(SW_OFS))) begin
      rd_val = switches;
    end else if (sel && (ofs == RAM_ADDR_BITS'(LED_OFS))) begin
      rd_val = led_q;
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// Round-robin CPU/video front end for the single-port data RAM; grants same cycle, rvalid 1 cycle later.
// Requesters hold until granted, responses are never stalled; MEM_ARBITER_MMIO_EN adds the CPU I/O window.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int                       WIDTH         = 16,
  parameter int                       RAM_ADDR_BITS = 16,
  parameter logic [RAM_ADDR_BITS-1:0] MMIO_BASE     = 16'hFF00
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic [RAM_ADDR_BITS-1:0] cpu_addr,
  input  logic [WIDTH-1:0]         cpu_wdata,
  output logic                     cpu_gnt,
  output logic                     cpu_rvalid,
  output logic [WIDTH-1:0]         cpu_rdata,
  input  logic                     vid_req,
  input  logic [RAM_ADDR_BITS-1:0] vid_addr,
  output logic                     vid_gnt,
  output logic                     vid_rvalid,
  output logic [WIDTH-1:0]         vid_rdata,
  output logic                     mem_en,
  output logic                     mem_write,
  output logic                     mem_read,
  output logic [RAM_ADDR_BITS-1:0] mem_adr,
  output logic [WIDTH-1:0]         mem_wdata,
  input  logic [WIDTH-1:0]         mem_rdata,
  input  logic [WIDTH-1:0]         switches,
  output logic [WIDTH-1:0]         leds
);
  requester_t       last_gnt;
  rd_owner_t        rd_owner, rd_owner_nxt;
  logic             cpu_mmio;
  logic             cpu_ram_req, cpu_ram_gnt, vid_ram_gnt, cpu_mmio_gnt;
  logic             mmio_rd_q;
  logic [WIDTH-1:0] mmio_rd_val, mmio_rdata_q, leds_q;

`ifdef MEM_ARBITER_MMIO_EN
  mem_mmio_regs #(
    .WIDTH(WIDTH), .RAM_ADDR_BITS(RAM_ADDR_BITS), .MMIO_BASE(MMIO_BASE)
  ) u_mmio (
    .clk      (clk),
    .reset    (reset),
    .addr     (cpu_addr),
    .wr       (cpu_mmio_gnt && cpu_we),
    .wdata    (cpu_wdata),
    .switches (switches),
    .sel      (cpu_mmio),
    .rd_val   (mmio_rd_val),
    .leds     (leds_q)
  );
`else
  logic unused_mmio;
  assign unused_mmio = ^{switches, MMIO_BASE};
  assign cpu_mmio    = 1'b0;
  assign mmio_rd_val = '0;
  assign leds_q      = '0;
`endif

  // Only RAM-bound requests compete; an MMIO access bypasses the arbiter entirely.
  always_comb begin
    cpu_ram_req  = cpu_req && !cpu_mmio;
    cpu_ram_gnt  = 1'b0;
    vid_ram_gnt  = 1'b0;
    cpu_mmio_gnt = !reset && cpu_req && cpu_mmio;
    if (!reset) begin
      if (cpu_ram_req && vid_req) begin
        cpu_ram_gnt = (last_gnt == VIDEO);
        vid_ram_gnt = (last_gnt == CPU);
      end else begin
        cpu_ram_gnt = cpu_ram_req;
        vid_ram_gnt = vid_req;
      end
    end
  end

  assign cpu_gnt   = cpu_ram_gnt || cpu_mmio_gnt;
  assign vid_gnt   = vid_ram_gnt;
  assign mem_en    = cpu_ram_gnt || vid_ram_gnt;
  assign mem_write = cpu_ram_gnt && cpu_we;
  assign mem_read  = mem_en && !mem_write;
  assign mem_adr   = cpu_ram_gnt ? cpu_addr : (vid_ram_gnt ? vid_addr : '0);
  assign mem_wdata = mem_write ? cpu_wdata : '0;

  always_comb begin
    rd_owner_nxt = NONE;
    if (cpu_ram_gnt && !cpu_we) begin
      rd_owner_nxt = CPU_RAM;
    end else if (vid_ram_gnt) begin
      rd_owner_nxt = VID_RAM;
    end
`ifdef MEM_ARBITER_MMIO_EN
    else if (cpu_mmio_gnt && !cpu_we) begin
      rd_owner_nxt = CPU_MMIO;
    end
`endif
  end

  // mmio_rd_q also covers an MMIO read that overlaps a video RAM read (rd_owner then says VID_RAM).
  always_ff @(posedge clk) begin
    if (reset) begin
      last_gnt     <= VIDEO;
      rd_owner     <= NONE;
      mmio_rd_q    <= 1'b0;
      mmio_rdata_q <= '0;
    end else begin
      if (cpu_ram_gnt) begin
        last_gnt <= CPU;
      end else if (vid_ram_gnt) begin
        last_gnt <= VIDEO;
      end
      rd_owner     <= rd_owner_nxt;
      mmio_rd_q    <= cpu_mmio_gnt && !cpu_we;
      mmio_rdata_q <= mmio_rd_val;
    end
  end

  assign cpu_rvalid = !reset && ((rd_owner == CPU_RAM) || mmio_rd_q);
  assign vid_rvalid = !reset && (rd_owner == VID_RAM);
  assign cpu_rdata  = !cpu_rvalid ? '0 : (mmio_rd_q ? mmio_rdata_q : mem_rdata);
  assign vid_rdata  = vid_rvalid ? mem_rdata : '0;
  assign leds       = reset ? '0 : leds_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table with a RAM model and a read-data scoreboard.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, vid_req;
  logic [15:0] cpu_addr, cpu_wdata, vid_addr, switches;
  logic        cpu_gnt, cpu_rvalid, vid_gnt, vid_rvalid;
  logic [15:0] cpu_rdata, vid_rdata;
  logic        mem_en, mem_write, mem_read;
  logic [15:0] mem_adr, mem_wdata, mem_rdata, leds;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt),
    .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
    .mem_en(mem_en), .mem_write(mem_write), .mem_read(mem_read),
    .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .switches(switches), .leds(leds)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst; logic cr; logic cwe; logic [15:0] ca; logic [15:0] cwd;
    logic vr; logic [15:0] va; logic [15:0] sw;
    logic cg; logic vg; logic men; logic mwr; logic [15:0] madr;
  } vec_t;

  typedef struct { int due; logic [15:0] dat; } exp_t;

  exp_t        cpu_q[$];
  exp_t        vid_q[$];
  vec_t        tbl[$];
  logic [15:0] ram [logic [15:0]];
  logic [15:0] ref_mem [logic [15:0]];
  logic [15:0] ref_leds = '0;
  int          cyc = 0;
  int          n_pass = 0;
  int          n_total = 0;

  function automatic logic [15:0] ram_rd(input logic [15:0] a);
    return ram.exists(a) ? ram[a] : (a ^ 16'h5A5A);
  endfunction

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : (a ^ 16'h5A5A);
  endfunction

  // Synchronous single-port RAM: write lands on the edge, read data appears after the edge.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_write) ram[mem_adr] = mem_wdata;
      else if (mem_read) mem_rdata <= ram_rd(mem_adr);
    end
  end

  function automatic logic is_mmio(input logic [15:0] a);
`ifdef MEM_ARBITER_MMIO_EN
    return a >= 16'hFF00;
`else
    return 1'b0;
`endif
  endfunction

  function automatic vec_t mk(input logic rst, input logic cr, input logic cwe,
                              input logic [15:0] ca, input logic [15:0] cwd,
                              input logic vr, input logic [15:0] va, input logic [15:0] sw,
                              input logic cg, input logic vg, input logic men,
                              input logic mwr, input logic [15:0] madr);
    vec_t t;
    t.rst = rst; t.cr = cr; t.cwe = cwe; t.ca = ca; t.cwd = cwd;
    t.vr = vr; t.va = va; t.sw = sw;
    t.cg = cg; t.vg = vg; t.men = men; t.mwr = mwr; t.madr = madr;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic apply(input vec_t t, input string nm);
    exp_t e;
    reset = t.rst; cpu_req = t.cr; cpu_we = t.cwe; cpu_addr = t.ca; cpu_wdata = t.cwd;
    vid_req = t.vr; vid_addr = t.va; switches = t.sw;
    if (t.rst) begin
      cpu_q.delete();
      vid_q.delete();
      ref_leds = '0;
    end
    @(negedge clk);
    chk({nm, ".cpu_gnt"}, 32'(cpu_gnt), 32'(t.cg));
    chk({nm, ".vid_gnt"}, 32'(vid_gnt), 32'(t.vg));
    chk({nm, ".mem_en"}, 32'(mem_en), 32'(t.men));
    chk({nm, ".mem_write"}, 32'(mem_write), 32'(t.mwr));
    chk({nm, ".mem_read"}, 32'(mem_read), 32'(t.men & ~t.mwr));
    if (t.men) chk({nm, ".mem_adr"}, 32'(mem_adr), 32'(t.madr));
    if (t.mwr) chk({nm, ".mem_wdata"}, 32'(mem_wdata), 32'(t.cwd));
    chk({nm, ".leds"}, 32'(leds), 32'(ref_leds));
    if (cpu_q.size() > 0 && cpu_q[0].due == cyc) begin
      chk({nm, ".cpu_rvalid"}, 32'(cpu_rvalid), 32'd1);
      chk({nm, ".cpu_rdata"}, 32'(cpu_rdata), 32'(cpu_q[0].dat));
      void'(cpu_q.pop_front());
    end else begin
      chk({nm, ".cpu_rvalid"}, 32'(cpu_rvalid), 32'd0);
      chk({nm, ".cpu_rdata"}, 32'(cpu_rdata), 32'd0);
    end
    if (vid_q.size() > 0 && vid_q[0].due == cyc) begin
      chk({nm, ".vid_rvalid"}, 32'(vid_rvalid), 32'd1);
      chk({nm, ".vid_rdata"}, 32'(vid_rdata), 32'(vid_q[0].dat));
      void'(vid_q.pop_front());
    end else begin
      chk({nm, ".vid_rvalid"}, 32'(vid_rvalid), 32'd0);
      chk({nm, ".vid_rdata"}, 32'(vid_rdata), 32'd0);
    end
    if (!t.rst && t.cr && t.cg) begin
      e.due = cyc + 1;
      if (is_mmio(t.ca)) begin
        if (t.cwe) begin
          if (t.ca == 16'hFF01) ref_leds = t.cwd;
        end else begin
          e.dat = (t.ca == 16'hFF00) ? t.sw : (t.ca == 16'hFF01) ? ref_leds : 16'h0000;
          cpu_q.push_back(e);
        end
      end else if (t.cwe) begin
        ref_mem[t.ca] = t.cwd;
      end else begin
        e.dat = ref_rd(t.ca);
        cpu_q.push_back(e);
      end
    end
    if (!t.rst && t.vr && t.vg) begin
      e.due = cyc + 1;
      e.dat = ref_rd(t.va);
      vid_q.push_back(e);
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  initial begin
    // Reset state
    tbl.push_back(mk(1, 0,0,16'h0000,16'h0000, 0,16'h0000,16'h0000, 0,0,0,0,16'h0000));
    tbl.push_back(mk(1, 0,0,16'h0000,16'h0000, 0,16'h0000,16'h0000, 0,0,0,0,16'h0000));
    // Both masters contend out of reset: CPU, VID, CPU, VID
    tbl.push_back(mk(0, 1,0,16'h0200,16'h0000, 1,16'h0300,16'h0000, 1,0,1,0,16'h0200));
    tbl.push_back(mk(0, 1,0,16'h0201,16'h0000, 1,16'h0300,16'h0000, 0,1,1,0,16'h0300));
    tbl.push_back(mk(0, 1,0,16'h0201,16'h0000, 1,16'h0301,16'h0000, 1,0,1,0,16'h0201));
    tbl.push_back(mk(0, 1,0,16'h0202,16'h0000, 1,16'h0301,16'h0000, 0,1,1,0,16'h0301));
    // Write then read-back of the same address on consecutive cycles
    tbl.push_back(mk(0, 1,1,16'h0010,16'h1234, 0,16'h0000,16'h0000, 1,0,1,1,16'h0010));
    tbl.push_back(mk(0, 1,0,16'h0010,16'h0000, 0,16'h0000,16'h0000, 1,0,1,0,16'h0010));
    // Video streaming alone
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0, 0,0,16'h0000,16'h0000, 1,16'h0100 + 16'(i),16'h0000,
                       0,1,1,0,16'h0100 + 16'(i)));
    // Tie after a CPU grant goes to video
    tbl.push_back(mk(0, 1,1,16'h0040,16'hBEEF, 0,16'h0000,16'h0000, 1,0,1,1,16'h0040));
    tbl.push_back(mk(0, 1,0,16'h0040,16'h0000, 1,16'h0041,16'h0000, 0,1,1,0,16'h0041));
    tbl.push_back(mk(0, 1,0,16'h0040,16'h0000, 0,16'h0000,16'h0000, 1,0,1,0,16'h0040));
    tbl.push_back(mk(0, 0,0,16'h0000,16'h0000, 0,16'h0000,16'h0000, 0,0,0,0,16'h0000));
`ifdef MEM_ARBITER_MMIO_EN
    tbl.push_back(mk(0, 1,1,16'hFF01,16'h00AA, 1,16'h0020,16'h0000, 1,1,1,0,16'h0020));
    tbl.push_back(mk(0, 1,0,16'hFF00,16'h0000, 0,16'h0000,16'h0005, 1,0,0,0,16'h0000));
    tbl.push_back(mk(0, 1,0,16'hFF01,16'h0000, 1,16'h0021,16'h0000, 1,1,1,0,16'h0021));
    tbl.push_back(mk(0, 1,1,16'hFF00,16'h7777, 0,16'h0000,16'h0000, 1,0,0,0,16'h0000));
    tbl.push_back(mk(0, 1,0,16'hFF00,16'h0000, 0,16'h0000,16'h0009, 1,0,0,0,16'h0000));
    tbl.push_back(mk(0, 1,0,16'hFF05,16'h0000, 0,16'h0000,16'h0000, 1,0,0,0,16'h0000));
    // MMIO grants leave last_gnt at VIDEO, so the CPU wins this tie
    tbl.push_back(mk(0, 1,0,16'h0010,16'h0000, 1,16'h0011,16'h0000, 1,0,1,0,16'h0010));
    tbl.push_back(mk(0, 0,0,16'h0000,16'h0000, 1,16'h0011,16'h0000, 0,1,1,0,16'h0011));
`else
    tbl.push_back(mk(0, 1,1,16'hFF01,16'h00AA, 0,16'h0000,16'h0000, 1,0,1,1,16'hFF01));
    tbl.push_back(mk(0, 1,0,16'hFF01,16'h0000, 0,16'h0000,16'h0000, 1,0,1,0,16'hFF01));
`endif
    tbl.push_back(mk(0, 0,0,16'h0000,16'h0000, 0,16'h0000,16'h0000, 0,0,0,0,16'h0000));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("v%0d", i));

    // Read in flight when reset hits, request held through reset
    apply(mk(0, 1,0,16'h0010,16'h0000, 0,16'h0000,16'h0000, 1,0,1,0,16'h0010), "rst_acc");
    apply(mk(1, 1,0,16'h0010,16'h0000, 0,16'h0000,16'h0000, 0,0,0,0,16'h0000), "rst_a");
    apply(mk(1, 1,0,16'h0010,16'h0000, 1,16'h0012,16'h0000, 0,0,0,0,16'h0000), "rst_b");
    apply(mk(0, 1,0,16'h0010,16'h0000, 0,16'h0000,16'h0000, 1,0,1,0,16'h0010), "rst_rel");
    apply(mk(0, 0,0,16'h0000,16'h0000, 0,16'h0000,16'h0000, 0,0,0,0,16'h0000), "rst_drain");
    apply(mk(0, 0,0,16'h0000,16'h0000, 0,16'h0000,16'h0000, 0,0,0,0,16'h0000), "tail");

    chk("sb_cpu_empty", 32'(cpu_q.size()), 32'd0);
    chk("sb_vid_empty", 32'(vid_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
